// File: rtl/ex_stage_pipe_pkg.sv
// ex_pkg: shared funct codes, MEM control bit indices and execute FSM states
package ex_pkg;
    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_SUB  = 3'b001;
    localparam logic [2:0] FN_AND  = 3'b010;
    localparam logic [2:0] FN_OR   = 3'b011;
    localparam logic [2:0] FN_SLT  = 3'b100;
    localparam logic [2:0] FN_SHL  = 3'b101;
    localparam logic [2:0] FN_MUL  = 3'b110;
    localparam logic [2:0] FN_PASS = 3'b111;
    localparam int CTRL_JC  = 0;
    localparam int CTRL_J   = 1;
    localparam int CTRL_NEQ = 2;
    localparam int CTRL_RM  = 3;
    localparam int CTRL_WM  = 4;
    localparam int CTRL_WR  = 5;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        MUL_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ex_stage_pipe_seq_mul.sv
// seq_mul: shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mc, mp, acc;
    // product includes the current step, so it is final while done is high and stays
    // final afterwards because the multiplier register has drained to zero
    assign product = acc + (mp[0] ? mc : '0);
    assign done    = cnt == CW'(1);
    // load operands on start, then retire one multiplier bit per cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            mc  <= '0;
            mp  <= '0;
            acc <= '0;
        end else if (start) begin
            cnt <= CW'(WIDTH);
            mc  <= a;
            mp  <= b;
            acc <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            mc  <= mc << 1;
            mp  <= mp >> 1;
            acc <= product;
        end
    end
endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: handshaked execute stage with accumulator, carry flag and sequential multiplier
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int FUNCT_W = 3,
    parameter int SH_W    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   reg_val,
    input  logic [WIDTH-1:0]   imm,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               use_imm,
    input  logic               acc_wr,
    input  logic [5:0]         ctrl_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               carry,
    output logic [WIDTH-1:0]   br_target,
    output logic [WIDTH-1:0]   rs_out,
    output logic [5:0]         ctrl_out,
    output logic               busy
);
    state_t           state, next;
    logic [WIDTH-1:0] a, b, alu_res, product, acc_q, bt_q, rs_q;
    logic [WIDTH:0]   sum, diff;
    logic [5:0]       ctrl_q;
    logic             alu_c, wr_q, accept, is_mul, slot_free, mul_done, fin_alu, fin_mul;
    assign a         = reg_val;
    assign b         = use_imm ? imm : acc_q;
    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = {1'b0, a} - {1'b0, b};
    assign is_mul    = funct == FN_MUL;
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && slot_free;
    assign busy      = state == MUL;
    assign accept    = in_valid && in_ready;
    assign fin_alu   = accept && !is_mul;
    assign fin_mul   = ((state == MUL && mul_done) || state == MUL_DONE) && slot_free;
    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );
    // single-cycle ALU result and carry/borrow
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (funct)
            FN_ADD:  {alu_c, alu_res} = sum;
            FN_SUB:  {alu_c, alu_res} = diff;
            FN_AND:  alu_res = a & b;
            FN_OR:   alu_res = a | b;
            FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            FN_SHL:  alu_res = a << b[SH_W-1:0];
            FN_PASS: alu_res = b;
            default: alu_res = '0;
        endcase
    end
    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end
    // next state: a finished product waits in MUL_DONE only if the slot is still occupied
    always_comb begin
        next = state;
        if (state == IDLE && accept && is_mul)    next = MUL;
        else if (state == MUL && mul_done)        next = slot_free ? IDLE : MUL_DONE;
        else if (state == MUL_DONE && slot_free)  next = IDLE;
    end
    // operand side-band latch, output slot and accumulator write-back
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bt_q      <= '0;
            rs_q      <= '0;
            ctrl_q    <= '0;
            wr_q      <= 1'b0;
            acc_q     <= '0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            br_target <= '0;
            rs_out    <= '0;
            ctrl_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                bt_q   <= pc + imm;
                rs_q   <= reg_val;
                ctrl_q <= ctrl_in;
                wr_q   <= acc_wr;
            end
            if (fin_alu) begin
                result    <= alu_res;
                zero      <= alu_res == '0;
                carry     <= alu_c;
                br_target <= pc + imm;
                rs_out    <= reg_val;
                ctrl_out  <= ctrl_in;
                if (acc_wr) acc_q <= alu_res;
            end else if (fin_mul) begin
                result    <= product;
                zero      <= product == '0;
                carry     <= 1'b0;
                br_target <= bt_q;
                rs_out    <= rs_q;
                ctrl_out  <= ctrl_q;
                if (wr_q) acc_q <= product;
            end
            out_valid <= (fin_alu || fin_mul) ? 1'b1 : (out_ready ? 1'b0 : out_valid);
        end
    end
endmodule
